cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Control FSM for the 2-way set-associative, 256 B, 16 B-line, write-back/write-allocate blocking cache datapath.
- Accepts one processor request at a time over val/rdy and sequences the datapath's tag/data arrays, registers and muxes through hit, evict and refill paths.
- Owns the valid, dirty and LRU state bits.
- Drives 16 B memory requests over val/rdy.

Parameters:
- p_idx_shamt, 0, index bit offset: index = addr[6+p_idx_shamt:4+p_idx_shamt]; must match the datapath's value.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cachereq_val / cachereq_rdy  in / out  1 / 1  processor request handshake
- cacheresp_val / cacheresp_rdy  out / in  1 / 1  processor response handshake
- memreq_val / memreq_rdy  out / in  1 / 1  memory request handshake
- memresp_val / memresp_rdy  in / out  1 / 1  memory response handshake
- cachereq_type  in  3  registered request type: 0 read, 1 write, 2 init
- cachereq_addr  in  32  registered request address
- tag_match0, tag_match1  in  1 each  datapath tag comparator outputs
- cachereq_en, tag_array_ren, tag_array_wen0, tag_array_wen1, tag_check_en, hit_reg_en, victim_reg_en, evict_addr_reg_en  out  1 each  datapath register/array enables
- tag_check_hit  out  2  hit code to hit_reg: 1 hit, 0 miss/init
- victim, victim_sel  out  1 each  victim way; 1 selects latched victim as way index
- data_array_ren, data_array_wen  out  1 each  data array enables
- data_array_wben  out  16  byte write enables
- write_data_mux_sel  out  1  1 = replicated request word, 0 = refill line
- read_data_reg_en, memresp_data_reg_en  out  1 each  line register enables
- read_word_mux_sel  out  3  0 = zero, 1..4 = word 0..3
- memreq_addr_mux_sel  out  1  0 = refill address, 1 = evict address
- memreq_type  out  3  0 read, 1 write

Behaviour:
- State encoding:
  - Registered state.
  - All outputs are a combinational decode of state plus inputs.
  - While reset is low, all outputs are 0 and state is IDLE.
  - valid[2][8], dirty[2][8], lru[8] are cleared to 0 asynchronously.
  - A reset mid-transaction abandons it. No response is issued.
- Address fields: idx as above; word offset off = cachereq_addr[3:2].
- hit = (tag_match0 & valid0[idx]) | (tag_match1 & valid1[idx]). Victim = lru[idx].
- lru[idx] is set to the opposite of the accessed way on every read/write access, refill and init.
- miss_r flag:
  - Set on a TAG_CHECK miss or init; cleared in IDLE.
  - victim_sel = 1 in EVICT_*, REFILL_* and INIT states, and whenever miss_r = 1.
- IDLE: cachereq_rdy = 1. On cachereq_val: cachereq_en = 1 → TAG_CHECK.
- TAG_CHECK: tag_array_ren, tag_check_en, hit_reg_en, victim_reg_en asserted; victim = lru[idx].
  - init → INIT_DATA_ACCESS.
  - Hit: tag_check_hit = 1 → READ_DATA_ACCESS (read) or WRITE_DATA_ACCESS (write).
  - Miss: evict_addr_reg_en = 1. If valid & dirty of the victim way → EVICT_PREPARE, else → REFILL_REQUEST.
- INIT_DATA_ACCESS:
  - Victim way: tag wen, data_array_wen, wben = 16'hF << 4*off, write_data_mux_sel = 1.
  - Set valid, clear dirty → WAIT.
- READ_DATA_ACCESS: data_array_ren, read_data_reg_en → WAIT.
- WRITE_DATA_ACCESS: data_array_wen, word wben, mux_sel = 1, set dirty → WAIT.
- EVICT_PREPARE: data_array_ren, read_data_reg_en → EVICT_REQUEST.
- EVICT_REQUEST: memreq_val, memreq_type = 1, addr_mux_sel = 1. Advance only when memreq_rdy → EVICT_WAIT.
- EVICT_WAIT: memresp_rdy = 1. On memresp_val → REFILL_REQUEST.
- REFILL_REQUEST: memreq_val, memreq_type = 0, addr_mux_sel = 0. On memreq_rdy → REFILL_WAIT.
- REFILL_WAIT: memresp_rdy = 1. On memresp_val: memresp_data_reg_en = 1 → REFILL_UPDATE.
- REFILL_UPDATE:
  - data_array_wen, wben = 16'hFFFF, mux_sel = 0, tag wen of victim way.
  - Set valid, clear dirty → READ_DATA_ACCESS or WRITE_DATA_ACCESS per type.
- WAIT:
  - cacheresp_val = 1; read_word_mux_sel = off+1 for read, 0 otherwise.
  - On cacheresp_rdy → IDLE. Hold all datapath state while stalled.
- Never asserts cachereq_rdy outside IDLE. At most one outstanding memory request.
- Only the victim way's tag_array_wen is ever asserted; wen0 and wen1 are never high together.
- Latency, with all rdy inputs high:
  - Hit: 4 cycles, request accept to response valid.
  - Clean miss: 7 cycles + memory latency.
  - Dirty miss: 10 cycles + memory latency.

Decomposition:
- cache_ctrl_pkg holds:
  - state enum (12 states);
  - request/memory type constants (READ = 0, WRITE = 1, INIT = 2);
  - word-mask function.
- One sub-module, cache_ctrl_state_bits: valid/dirty/LRU arrays with async-low clear, idx-addressed set/clear/update ports.

Test Plan:
- init 0x0000_0010 data 0xDEADBEEF, then read 0x10 → two responses; read has hit code 1, data 0xDEADBEEF, no memreq.
- Read 0x0000_1000 cold, memresp line word0 = 0x11111111 → one memreq type 0, addr 0x1000; response hit code 0, data 0x11111111.
- Dirty eviction:
  - Stimulus: write 0x0000_0100 = 0xA5, then misses 0x0000_0180 and 0x0000_0200 to the same set.
  - Required: third access issues memreq type 1, addr 0x100, word0 0xA5, before refill read of 0x200.
- LRU order: after accesses to 0x100 and 0x180, a read of 0x100 then a miss to 0x200 → evicts 0x180's way.
- Backpressure: hold memreq_rdy and cacheresp_rdy low 5 cycles → val held stable, no state advance, cachereq_rdy stays 0.
- Assert reset in REFILL_WAIT → all outputs 0 immediately. After release, a read of the same address misses (valid cleared).

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared FSM state encoding, request type codes and byte-mask helper for the
// 2-way write-back cache controller.
package cache_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        TAG_CHECK,
        INIT_DATA_ACCESS,
        READ_DATA_ACCESS,
        WRITE_DATA_ACCESS,
        EVICT_PREPARE,
        EVICT_REQUEST,
        EVICT_WAIT,
        REFILL_REQUEST,
        REFILL_WAIT,
        REFILL_UPDATE,
        WAIT
    } state_e;

    localparam logic [2:0] TYPE_READ  = 3'd0;
    localparam logic [2:0] TYPE_WRITE = 3'd1;
    localparam logic [2:0] TYPE_INIT  = 3'd2;

    localparam int NUM_SETS = 8;
    localparam int IDX_W    = 3;

    // Byte enables covering one 32-bit word of the 16 B line.
    function automatic logic [15:0] word_mask(input logic [1:0] off);
        return 16'h000F << {off, 2'b00};
    endfunction

endpackage

// File: rtl/cache_ctrl_state_bits.sv
// Per-set valid/dirty bits for both ways plus one LRU bit per set, all
// addressed by the current request index.
module cache_ctrl_state_bits
    import cache_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] idx,
    input  logic             way,
    input  logic             fill_en,
    input  logic             dirty_en,
    input  logic             lru_en,
    output logic [1:0]       valid,
    output logic [1:0]       dirty,
    output logic             lru
);

    logic [1:0][NUM_SETS-1:0] valid_q, valid_d;
    logic [1:0][NUM_SETS-1:0] dirty_q, dirty_d;
    logic [NUM_SETS-1:0]      lru_q, lru_d;

    // A fill installs a clean line; lru points at the way not just touched.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        lru_d   = lru_q;
        if (fill_en) begin
            valid_d[way][idx] = 1'b1;
            dirty_d[way][idx] = 1'b0;
        end
        if (dirty_en) dirty_d[way][idx] = 1'b1;
        if (lru_en)   lru_d[idx] = ~way;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            lru_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            lru_q   <= lru_d;
        end
    end

    assign valid = {valid_q[1][idx], valid_q[0][idx]};
    assign dirty = {dirty_q[1][idx], dirty_q[0][idx]};
    assign lru   = lru_q[idx];

endmodule

// File: rtl/cache_ctrl.sv
// Blocking cache control FSM: sequences tag check, hit access, dirty eviction
// and refill for a 2-way, 16 B-line write-back/write-allocate datapath.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int p_idx_shamt = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cachereq_val,
    output logic        cachereq_rdy,
    output logic        cacheresp_val,
    input  logic        cacheresp_rdy,
    output logic        memreq_val,
    input  logic        memreq_rdy,
    input  logic        memresp_val,
    output logic        memresp_rdy,
    input  logic [2:0]  cachereq_type,
    input  logic [31:0] cachereq_addr,
    input  logic        tag_match0,
    input  logic        tag_match1,
    output logic        cachereq_en,
    output logic        tag_array_ren,
    output logic        tag_array_wen0,
    output logic        tag_array_wen1,
    output logic        tag_check_en,
    output logic [1:0]  tag_check_hit,
    output logic        hit_reg_en,
    output logic        victim_reg_en,
    output logic        evict_addr_reg_en,
    output logic        victim,
    output logic        victim_sel,
    output logic        data_array_ren,
    output logic        data_array_wen,
    output logic [15:0] data_array_wben,
    output logic        write_data_mux_sel,
    output logic        read_data_reg_en,
    output logic        memresp_data_reg_en,
    output logic [2:0]  read_word_mux_sel,
    output logic        memreq_addr_mux_sel,
    output logic [2:0]  memreq_type
);

    state_e           state_q, state_d;
    logic             miss_q, miss_d;
    logic             way_q, way_d;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [1:0]       valid, dirty;
    logic             lru;
    logic             hit, hit_way;
    logic             fill_en, dirty_en, lru_en;
    logic             is_write, is_init;
    logic             unused_addr;

    assign idx         = cachereq_addr[6+p_idx_shamt:4+p_idx_shamt];
    assign off         = cachereq_addr[3:2];
    assign unused_addr = ^cachereq_addr;
    assign is_write    = (cachereq_type == TYPE_WRITE);
    assign is_init     = (cachereq_type == TYPE_INIT);
    assign hit         = (tag_match0 & valid[0]) | (tag_match1 & valid[1]);
    assign hit_way     = ~(tag_match0 & valid[0]);

    cache_ctrl_state_bits u_state_bits (
        .clk      (clk),
        .reset    (reset),
        .idx      (idx),
        .way      (way_q),
        .fill_en  (fill_en),
        .dirty_en (dirty_en),
        .lru_en   (lru_en),
        .valid    (valid),
        .dirty    (dirty),
        .lru      (lru)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            miss_q  <= 1'b0;
            way_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            way_q   <= way_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        miss_d              = miss_q;
        way_d               = way_q;
        fill_en             = 1'b0;
        dirty_en            = 1'b0;
        lru_en              = 1'b0;
        cachereq_rdy        = 1'b0;
        cacheresp_val       = 1'b0;
        memreq_val          = 1'b0;
        memresp_rdy         = 1'b0;
        cachereq_en         = 1'b0;
        tag_array_ren       = 1'b0;
        tag_array_wen0      = 1'b0;
        tag_array_wen1      = 1'b0;
        tag_check_en        = 1'b0;
        tag_check_hit       = 2'd0;
        hit_reg_en          = 1'b0;
        victim_reg_en       = 1'b0;
        evict_addr_reg_en   = 1'b0;
        victim              = 1'b0;
        victim_sel          = 1'b0;
        data_array_ren      = 1'b0;
        data_array_wen      = 1'b0;
        data_array_wben     = 16'h0000;
        write_data_mux_sel  = 1'b0;
        read_data_reg_en    = 1'b0;
        memresp_data_reg_en = 1'b0;
        read_word_mux_sel   = 3'd0;
        memreq_addr_mux_sel = 1'b0;
        memreq_type         = TYPE_READ;
        // Outputs are forced low for the whole reset assertion, not just at the edge.
        if (reset) begin
            victim_sel = miss_q;
            unique case (state_q)
                IDLE: begin
                    cachereq_rdy = 1'b1;
                    miss_d       = 1'b0;
                    if (cachereq_val) begin
                        cachereq_en = 1'b1;
                        state_d     = TAG_CHECK;
                    end
                end
                TAG_CHECK: begin
                    tag_array_ren = 1'b1;
                    tag_check_en  = 1'b1;
                    hit_reg_en    = 1'b1;
                    victim_reg_en = 1'b1;
                    victim        = lru;
                    if (is_init) begin
                        miss_d  = 1'b1;
                        way_d   = lru;
                        state_d = INIT_DATA_ACCESS;
                    end else if (hit) begin
                        tag_check_hit = 2'd1;
                        way_d         = hit_way;
                        state_d       = is_write ? WRITE_DATA_ACCESS : READ_DATA_ACCESS;
                    end else begin
                        evict_addr_reg_en = 1'b1;
                        miss_d            = 1'b1;
                        way_d             = lru;
                        state_d = (valid[lru] & dirty[lru]) ? EVICT_PREPARE : REFILL_REQUEST;
                    end
                end
                INIT_DATA_ACCESS: begin
                    victim_sel         = 1'b1;
                    tag_array_wen0     = ~way_q;
                    tag_array_wen1     = way_q;
                    data_array_wen     = 1'b1;
                    data_array_wben    = word_mask(off);
                    write_data_mux_sel = 1'b1;
                    fill_en            = 1'b1;
                    lru_en             = 1'b1;
                    state_d            = WAIT;
                end
                READ_DATA_ACCESS: begin
                    data_array_ren   = 1'b1;
                    read_data_reg_en = 1'b1;
                    lru_en           = 1'b1;
                    state_d          = WAIT;
                end
                WRITE_DATA_ACCESS: begin
                    data_array_wen     = 1'b1;
                    data_array_wben    = word_mask(off);
                    write_data_mux_sel = 1'b1;
                    dirty_en           = 1'b1;
                    lru_en             = 1'b1;
                    state_d            = WAIT;
                end
                EVICT_PREPARE: begin
                    victim_sel       = 1'b1;
                    data_array_ren   = 1'b1;
                    read_data_reg_en = 1'b1;
                    state_d          = EVICT_REQUEST;
                end
                EVICT_REQUEST: begin
                    victim_sel          = 1'b1;
                    memreq_val          = 1'b1;
                    memreq_type         = TYPE_WRITE;
                    memreq_addr_mux_sel = 1'b1;
                    if (memreq_rdy) state_d = EVICT_WAIT;
                end
                EVICT_WAIT: begin
                    victim_sel  = 1'b1;
                    memresp_rdy = 1'b1;
                    if (memresp_val) state_d = REFILL_REQUEST;
                end
                REFILL_REQUEST: begin
                    victim_sel = 1'b1;
                    memreq_val = 1'b1;
                    if (memreq_rdy) state_d = REFILL_WAIT;
                end
                REFILL_WAIT: begin
                    victim_sel  = 1'b1;
                    memresp_rdy = 1'b1;
                    if (memresp_val) begin
                        memresp_data_reg_en = 1'b1;
                        state_d             = REFILL_UPDATE;
                    end
                end
                REFILL_UPDATE: begin
                    victim_sel      = 1'b1;
                    tag_array_wen0  = ~way_q;
                    tag_array_wen1  = way_q;
                    data_array_wen  = 1'b1;
                    data_array_wben = 16'hFFFF;
                    fill_en         = 1'b1;
                    lru_en          = 1'b1;
                    state_d         = is_write ? WRITE_DATA_ACCESS : READ_DATA_ACCESS;
                end
                WAIT: begin
                    cacheresp_val = 1'b1;
                    if (cachereq_type == TYPE_READ) read_word_mux_sel = {1'b0, off} + 3'd1;
                    if (cacheresp_rdy) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed cycle-by-cycle check of the cache control FSM: each vector gives
// the inputs for one cycle and the full set of control outputs expected.
module tb_cache_ctrl;

    typedef struct packed {
        logic        req_rdy;
        logic        req_en;
        logic        tag_ren;
        logic        tc_en;
        logic        hit_en;
        logic        vic_en;
        logic        evict_en;
        logic [1:0]  hit;
        logic        victim;
        logic        vsel;
        logic [1:0]  tag_wen;   // {wen1, wen0}
        logic        d_ren;
        logic        d_wen;
        logic [15:0] wben;
        logic        wd_sel;
        logic        rdr_en;
        logic        mdr_en;
        logic        resp_val;
        logic [2:0]  rw_sel;
        logic        mreq_val;
        logic [2:0]  mreq_type;
        logic        addr_sel;
        logic        mresp_rdy;
    } obs_t;

    typedef struct {
        logic        val;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [1:0]  tm;    // {tag_match1, tag_match0}
        logic [2:0]  rdys;  // {cacheresp_rdy, memreq_rdy, memresp_val}
        obs_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cachereq_val = 1'b0, cacheresp_rdy = 1'b1, memreq_rdy = 1'b1, memresp_val = 1'b1;
    logic [2:0]  cachereq_type = 3'd0;
    logic [31:0] cachereq_addr = 32'h0;
    logic        tag_match0 = 1'b0, tag_match1 = 1'b0;
    logic        cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy;
    logic        cachereq_en, tag_array_ren, tag_array_wen0, tag_array_wen1, tag_check_en;
    logic [1:0]  tag_check_hit;
    logic        hit_reg_en, victim_reg_en, evict_addr_reg_en, victim, victim_sel;
    logic        data_array_ren, data_array_wen, write_data_mux_sel;
    logic [15:0] data_array_wben;
    logic        read_data_reg_en, memresp_data_reg_en, memreq_addr_mux_sel;
    logic [2:0]  read_word_mux_sel, memreq_type;

    obs_t act;
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] a;
    logic [2:0]  t;

    always #5 clk = ~clk;

    cache_ctrl #(.p_idx_shamt(0)) dut (
        .clk(clk), .reset(reset),
        .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy),
        .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .cachereq_type(cachereq_type), .cachereq_addr(cachereq_addr),
        .tag_match0(tag_match0), .tag_match1(tag_match1),
        .cachereq_en(cachereq_en), .tag_array_ren(tag_array_ren),
        .tag_array_wen0(tag_array_wen0), .tag_array_wen1(tag_array_wen1),
        .tag_check_en(tag_check_en), .tag_check_hit(tag_check_hit),
        .hit_reg_en(hit_reg_en), .victim_reg_en(victim_reg_en),
        .evict_addr_reg_en(evict_addr_reg_en), .victim(victim), .victim_sel(victim_sel),
        .data_array_ren(data_array_ren), .data_array_wen(data_array_wen),
        .data_array_wben(data_array_wben), .write_data_mux_sel(write_data_mux_sel),
        .read_data_reg_en(read_data_reg_en), .memresp_data_reg_en(memresp_data_reg_en),
        .read_word_mux_sel(read_word_mux_sel), .memreq_addr_mux_sel(memreq_addr_mux_sel),
        .memreq_type(memreq_type)
    );

    always_comb begin
        act           = '0;
        act.req_rdy   = cachereq_rdy;
        act.req_en    = cachereq_en;
        act.tag_ren   = tag_array_ren;
        act.tc_en     = tag_check_en;
        act.hit_en    = hit_reg_en;
        act.vic_en    = victim_reg_en;
        act.evict_en  = evict_addr_reg_en;
        act.hit       = tag_check_hit;
        act.victim    = victim;
        act.vsel      = victim_sel;
        act.tag_wen   = {tag_array_wen1, tag_array_wen0};
        act.d_ren     = data_array_ren;
        act.d_wen     = data_array_wen;
        act.wben      = data_array_wben;
        act.wd_sel    = write_data_mux_sel;
        act.rdr_en    = read_data_reg_en;
        act.mdr_en    = memresp_data_reg_en;
        act.resp_val  = cacheresp_val;
        act.rw_sel    = read_word_mux_sel;
        act.mreq_val  = memreq_val;
        act.mreq_type = memreq_type;
        act.addr_sel  = memreq_addr_mux_sel;
        act.mresp_rdy = memresp_rdy;
    end

    // Expected output patterns, one per FSM state, with the varying fields as arguments.
    function automatic obs_t f_idle(input logic en, input logic vs);
        obs_t o = '0; o.req_rdy = 1'b1; o.req_en = en; o.vsel = vs; return o;
    endfunction
    function automatic obs_t f_tc(input logic [1:0] h, input logic vic, input logic ev, input logic vs);
        obs_t o = '0;
        o.tag_ren = 1'b1; o.tc_en = 1'b1; o.hit_en = 1'b1; o.vic_en = 1'b1;
        o.hit = h; o.victim = vic; o.evict_en = ev; o.vsel = vs; return o;
    endfunction
    function automatic obs_t f_init(input logic [1:0] tw, input logic [15:0] wb);
        obs_t o = '0; o.tag_wen = tw; o.d_wen = 1'b1; o.wben = wb; o.wd_sel = 1'b1; o.vsel = 1'b1; return o;
    endfunction
    function automatic obs_t f_rda(input logic vs);
        obs_t o = '0; o.d_ren = 1'b1; o.rdr_en = 1'b1; o.vsel = vs; return o;
    endfunction
    function automatic obs_t f_wda(input logic [15:0] wb, input logic vs);
        obs_t o = '0; o.d_wen = 1'b1; o.wben = wb; o.wd_sel = 1'b1; o.vsel = vs; return o;
    endfunction
    function automatic obs_t f_ep();
        obs_t o = '0; o.d_ren = 1'b1; o.rdr_en = 1'b1; o.vsel = 1'b1; return o;
    endfunction
    function automatic obs_t f_er();
        obs_t o = '0; o.mreq_val = 1'b1; o.mreq_type = 3'd1; o.addr_sel = 1'b1; o.vsel = 1'b1; return o;
    endfunction
    function automatic obs_t f_ew();
        obs_t o = '0; o.mresp_rdy = 1'b1; o.vsel = 1'b1; return o;
    endfunction
    function automatic obs_t f_rr();
        obs_t o = '0; o.mreq_val = 1'b1; o.vsel = 1'b1; return o;
    endfunction
    function automatic obs_t f_rw(input logic mv);
        obs_t o = '0; o.mresp_rdy = 1'b1; o.mdr_en = mv; o.vsel = 1'b1; return o;
    endfunction
    function automatic obs_t f_ru(input logic [1:0] tw);
        obs_t o = '0; o.tag_wen = tw; o.d_wen = 1'b1; o.wben = 16'hFFFF; o.vsel = 1'b1; return o;
    endfunction
    function automatic obs_t f_wait(input logic [2:0] rw, input logic vs);
        obs_t o = '0; o.resp_val = 1'b1; o.rw_sel = rw; o.vsel = vs; return o;
    endfunction

    task automatic add(input logic val, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [1:0] tm, input logic [2:0] rdys, input obs_t exp);
        vec_t v;
        v.val = val; v.typ = typ; v.addr = addr; v.tm = tm; v.rdys = rdys; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        cachereq_val  = v.val;
        cachereq_type = v.typ;
        cachereq_addr = v.addr;
        {tag_match1, tag_match0} = v.tm;
        {cacheresp_rdy, memreq_rdy, memresp_val} = v.rdys;
        #1;
        check(name, v.exp);
    endtask

    task automatic step(input string name, input logic val, input logic [2:0] typ, input logic [31:0] addr,
                        input logic [1:0] tm, input logic [2:0] rdys, input obs_t exp);
        vec_t v;
        v.val = val; v.typ = typ; v.addr = addr; v.tm = tm; v.rdys = rdys; v.exp = exp;
        apply(name, v);
    endtask

    initial begin
        // init 0x10 then read it back: pure hit path, no memory traffic
        t = 3'd2; a = 32'h0000_0010;
        add(1, t, a, 2'b00, 3'b111, f_idle(1, 0));
        add(0, t, a, 2'b00, 3'b111, f_tc(2'd0, 0, 0, 0));
        add(0, t, a, 2'b00, 3'b111, f_init(2'b01, 16'h000F));
        add(0, t, a, 2'b00, 3'b111, f_wait(3'd0, 1));
        t = 3'd0;
        add(1, t, a, 2'b00, 3'b111, f_idle(1, 1));
        add(0, t, a, 2'b01, 3'b111, f_tc(2'd1, 1, 0, 0));
        add(0, t, a, 2'b01, 3'b111, f_rda(0));
        add(0, t, a, 2'b01, 3'b111, f_wait(3'd1, 0));
        // cold read 0x1000: stale tag match on an invalid line must still miss
        a = 32'h0000_1000;
        add(1, t, a, 2'b00, 3'b111, f_idle(1, 0));
        add(0, t, a, 2'b01, 3'b111, f_tc(2'd0, 0, 1, 0));
        add(0, t, a, 2'b00, 3'b111, f_rr());
        add(0, t, a, 2'b00, 3'b111, f_rw(1));
        add(0, t, a, 2'b00, 3'b111, f_ru(2'b01));
        add(0, t, a, 2'b00, 3'b111, f_rda(1));
        add(0, t, a, 2'b00, 3'b111, f_wait(3'd1, 1));
        // write-allocate 0x100 into way 1, leaving it dirty
        t = 3'd1; a = 32'h0000_0100;
        add(1, t, a, 2'b00, 3'b111, f_idle(1, 1));
        add(0, t, a, 2'b00, 3'b111, f_tc(2'd0, 1, 1, 0));
        add(0, t, a, 2'b00, 3'b111, f_rr());
        add(0, t, a, 2'b00, 3'b111, f_rw(1));
        add(0, t, a, 2'b00, 3'b111, f_ru(2'b10));
        add(0, t, a, 2'b00, 3'b111, f_wda(16'h000F, 1));
        add(0, t, a, 2'b00, 3'b111, f_wait(3'd0, 1));
        // read 0x180 replaces the clean 0x1000 line in way 0
        t = 3'd0; a = 32'h0000_0180;
        add(1, t, a, 2'b00, 3'b111, f_idle(1, 1));
        add(0, t, a, 2'b00, 3'b111, f_tc(2'd0, 0, 1, 0));
        add(0, t, a, 2'b00, 3'b111, f_rr());
        add(0, t, a, 2'b00, 3'b111, f_rw(1));
        add(0, t, a, 2'b00, 3'b111, f_ru(2'b01));
        add(0, t, a, 2'b00, 3'b111, f_rda(1));
        add(0, t, a, 2'b00, 3'b111, f_wait(3'd1, 1));
        // read 0x200 evicts dirty 0x100 (way 1) under memreq and cacheresp backpressure
        a = 32'h0000_0200;
        add(1, t, a, 2'b00, 3'b111, f_idle(1, 1));
        add(0, t, a, 2'b00, 3'b111, f_tc(2'd0, 1, 1, 0));
        add(0, t, a, 2'b00, 3'b111, f_ep());
        for (int i = 0; i < 5; i++) add(0, t, a, 2'b00, 3'b100, f_er());
        add(0, t, a, 2'b00, 3'b111, f_er());
        add(0, t, a, 2'b00, 3'b110, f_ew());
        add(0, t, a, 2'b00, 3'b111, f_ew());
        add(0, t, a, 2'b00, 3'b111, f_rr());
        add(0, t, a, 2'b00, 3'b111, f_rw(1));
        add(0, t, a, 2'b00, 3'b111, f_ru(2'b10));
        add(0, t, a, 2'b00, 3'b111, f_rda(1));
        for (int i = 0; i < 5; i++) add(0, t, a, 2'b00, 3'b011, f_wait(3'd1, 1));
        add(0, t, a, 2'b00, 3'b111, f_wait(3'd1, 1));
        // LRU: touch 0x180 (hit way 0), refill 0x100 into way 1, touch 0x180 then 0x108
        a = 32'h0000_0180;
        add(1, t, a, 2'b00, 3'b111, f_idle(1, 1));
        add(0, t, a, 2'b01, 3'b111, f_tc(2'd1, 0, 0, 0));
        add(0, t, a, 2'b01, 3'b111, f_rda(0));
        add(0, t, a, 2'b01, 3'b111, f_wait(3'd1, 0));
        a = 32'h0000_0100;
        add(1, t, a, 2'b00, 3'b111, f_idle(1, 0));
        add(0, t, a, 2'b00, 3'b111, f_tc(2'd0, 1, 1, 0));
        add(0, t, a, 2'b00, 3'b111, f_rr());
        add(0, t, a, 2'b00, 3'b111, f_rw(1));
        add(0, t, a, 2'b00, 3'b111, f_ru(2'b10));
        add(0, t, a, 2'b00, 3'b111, f_rda(1));
        add(0, t, a, 2'b00, 3'b111, f_wait(3'd1, 1));
        a = 32'h0000_0180;
        add(1, t, a, 2'b00, 3'b111, f_idle(1, 1));
        add(0, t, a, 2'b01, 3'b111, f_tc(2'd1, 0, 0, 0));
        add(0, t, a, 2'b01, 3'b111, f_rda(0));
        add(0, t, a, 2'b01, 3'b111, f_wait(3'd1, 0));
        a = 32'h0000_0108;
        add(1, t, a, 2'b00, 3'b111, f_idle(1, 0));
        add(0, t, a, 2'b10, 3'b111, f_tc(2'd1, 1, 0, 0));
        add(0, t, a, 2'b10, 3'b111, f_rda(0));
        add(0, t, a, 2'b10, 3'b111, f_wait(3'd3, 0));
        // miss 0x200 must pick way 0 (0x180), which is clean: no eviction
        a = 32'h0000_0200;
        add(1, t, a, 2'b00, 3'b111, f_idle(1, 0));
        add(0, t, a, 2'b00, 3'b111, f_tc(2'd0, 0, 1, 0));
        add(0, t, a, 2'b00, 3'b111, f_rr());
        add(0, t, a, 2'b00, 3'b111, f_rw(1));
        add(0, t, a, 2'b00, 3'b111, f_ru(2'b01));
        add(0, t, a, 2'b00, 3'b111, f_rda(1));
        add(0, t, a, 2'b00, 3'b111, f_wait(3'd1, 1));

        // outputs held low while reset is asserted
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", '0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

        // reset while waiting for a refill: abandon, outputs drop at once, state bits cleared
        t = 3'd0; a = 32'h0000_1010;
        step("rst_idle", 1, t, a, 2'b00, 3'b111, f_idle(1, 1));
        step("rst_tc",   0, t, a, 2'b00, 3'b111, f_tc(2'd0, 1, 1, 0));
        step("rst_rr",   0, t, a, 2'b00, 3'b111, f_rr());
        step("rst_rw",   0, t, a, 2'b00, 3'b110, f_rw(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_async", '0);
        @(negedge clk);
        #1;
        check("rst_hold", '0);
        reset = 1'b1;
        a = 32'h0000_0010;
        step("post_idle", 1, t, a, 2'b00, 3'b111, f_idle(1, 0));
        step("post_tc",   0, t, a, 2'b01, 3'b111, f_tc(2'd0, 0, 1, 0));
        step("post_rr",   0, t, a, 2'b00, 3'b111, f_rr());
        step("post_rw",   0, t, a, 2'b00, 3'b111, f_rw(1));
        step("post_ru",   0, t, a, 2'b00, 3'b111, f_ru(2'b01));
        step("post_rda",  0, t, a, 2'b00, 3'b111, f_rda(1));
        step("post_wait", 0, t, a, 2'b00, 3'b111, f_wait(3'd1, 1));
        step("post_done", 0, t, a, 2'b00, 3'b111, f_idle(0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
